// File: rtl/led7219_pkg.sv
// Shared types and helpers for the MAX7219 frame arbiter.
// Byte n of the 256-bit frame lives at bits [255-8n -: 8].
package led7219_pkg;

    localparam int LED_FRAME_BYTES = 32;
    localparam int LED_FRAME_BITS  = 256;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWN0,
        ST_OWN1,
        ST_WAIT_SWAP
    } arb_state_t;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_REQ0 = 2'b01;
    localparam logic [1:0] OWNER_REQ1 = 2'b10;

    // MSB position of byte lane n inside the frame
    function automatic logic [7:0] byte_msb(input logic [4:0] n);
        return 8'(LED_FRAME_BITS - 1 - 8 * int'(n));
    endfunction

endpackage

// File: rtl/led7219_rr_grant.sv
// Two-input round-robin grant. The registered pointer names the requester
// that wins a tie; it moves to the other requester when the current owner
// releases the lock.
module led7219_rr_grant (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic release_en,
    input  logic release_id,   // 0: req0 released, 1: req1 released
    output logic gnt0,
    output logic gnt1
);

    logic ptr;                 // 0: req0 preferred, 1: req1 preferred

    // Pointer hands priority to the requester that did not just release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= 1'b0;
        else if (release_en)
            ptr <= ~release_id;
    end

    // A lone requester always wins; a tie goes to the pointer
    always_comb begin
        gnt0 = req0 & (~req1 | ~ptr);
        gnt1 = req1 & (~req0 |  ptr);
    end

endmodule

// File: rtl/led7219_frame_arb.sv
// Double-buffered LED frame shared by two byte-writing requesters.
// Requesters lock the back buffer, write bytes, then commit; the back buffer
// is copied to the front only after the front has been stable for a full
// driver refresh, so the chain never shows a torn frame.
// Optional: define LED_ARB_TIMEOUT_EN to revoke a lock after TIMEOUT_CYCLES
// idle cycles, discarding the partial update.
module led7219_frame_arb
    import led7219_pkg::*;
#(
    parameter int REFRESH_CYCLES = 52992
`ifdef LED_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [4:0]   req0_addr,
    input  logic [7:0]   req0_data,
    input  logic         req0_commit,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [4:0]   req1_addr,
    input  logic [7:0]   req1_data,
    input  logic         req1_commit,
    output logic [255:0] frame_out,
    output logic [1:0]   owner,
    output logic         swap_pulse
);

    localparam int HOLD_W = $clog2(REFRESH_CYCLES + 1);

    arb_state_t                state, state_nxt;
    logic [1:0]                owner_q, owner_nxt;
    logic [LED_FRAME_BITS-1:0] back, front;
    logic [HOLD_W-1:0]         hold_cnt;
    logic                      hold_sat;
    logic                      gnt0, gnt1;
    logic                      wr_en;
    logic [4:0]                wr_addr;
    logic [7:0]                wr_data;
    logic                      do_swap;
    logic                      rel_en;
    logic                      revert;

    assign hold_sat  = (hold_cnt == HOLD_W'(REFRESH_CYCLES));
    assign frame_out = front;
    assign owner     = owner_q;

    led7219_rr_grant u_grant (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0       (req0_valid),
        .req1       (req1_valid),
        .release_en (rel_en),
        .release_id (owner_q[1]),
        .gnt0       (gnt0),
        .gnt1       (gnt1)
    );

`ifdef LED_ARB_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [IDLE_W-1:0] idle_cnt;
    logic              owner_idle;

    assign owner_idle = (state == ST_OWN0 && !req0_valid) ||
                        (state == ST_OWN1 && !req1_valid);

    // Counts consecutive owner-idle cycles; any accepted transfer clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idle_cnt <= '0;
        else if (owner_idle && !revert)
            idle_cnt <= idle_cnt + 1'b1;
        else
            idle_cnt <= '0;
    end
`endif

    // Next-state, handshake and buffer-control decode
    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = req0_addr;
        wr_data    = req0_data;
        do_swap    = 1'b0;
        rel_en     = 1'b0;
        revert     = 1'b0;
        case (state)
            ST_IDLE: begin
                req0_ready = gnt0;
                req1_ready = gnt1;
                if (gnt0) begin
                    wr_en     = 1'b1;
                    owner_nxt = OWNER_REQ0;
                    state_nxt = req0_commit ? ST_WAIT_SWAP : ST_OWN0;
                end else if (gnt1) begin
                    wr_en     = 1'b1;
                    wr_addr   = req1_addr;
                    wr_data   = req1_data;
                    owner_nxt = OWNER_REQ1;
                    state_nxt = req1_commit ? ST_WAIT_SWAP : ST_OWN1;
                end
            end
            ST_OWN0: begin
                req0_ready = 1'b1;
                if (req0_valid) begin
                    wr_en = 1'b1;
                    if (req0_commit)
                        state_nxt = ST_WAIT_SWAP;
                end
`ifdef LED_ARB_TIMEOUT_EN
                else if (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                    revert    = 1'b1;
                    rel_en    = 1'b1;
                    owner_nxt = OWNER_NONE;
                    state_nxt = ST_IDLE;
                end
`endif
            end
            ST_OWN1: begin
                req1_ready = 1'b1;
                wr_addr    = req1_addr;
                wr_data    = req1_data;
                if (req1_valid) begin
                    wr_en = 1'b1;
                    if (req1_commit)
                        state_nxt = ST_WAIT_SWAP;
                end
`ifdef LED_ARB_TIMEOUT_EN
                else if (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                    revert    = 1'b1;
                    rel_en    = 1'b1;
                    owner_nxt = OWNER_NONE;
                    state_nxt = ST_IDLE;
                end
`endif
            end
            ST_WAIT_SWAP: begin
                if (hold_sat) begin
                    do_swap   = 1'b1;
                    rel_en    = 1'b1;
                    owner_nxt = OWNER_NONE;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, ownership and swap strobe registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            owner_q    <= OWNER_NONE;
            swap_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner_q    <= owner_nxt;
            swap_pulse <= do_swap;
        end
    end

    // Front-frame age: saturates at one refresh period, restarts on a swap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hold_cnt <= '0;
        else if (do_swap)
            hold_cnt <= '0;
        else if (!hold_sat)
            hold_cnt <= hold_cnt + 1'b1;
    end

    // Back buffer takes byte writes (or is restored); front copies back on swap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            back  <= '0;
            front <= '0;
        end else begin
            if (do_swap)
                front <= back;
            if (revert)
                back <= front;
            else if (wr_en)
                back[byte_msb(wr_addr) -: 8] <= wr_data;
        end
    end

endmodule
